// File: rtl/axi_arbiter_nm.sv
// N-master to 1-slave AXI4 arbiter with independent read and write FSMs, one transaction in flight per path.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module axi_arbiter_nm #(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_M*(ADDR_W+ID_W+13)-1:0]        s_ar_bus,
   input  logic [NUM_M-1:0]                         s_arvalid,
   output logic [NUM_M-1:0]                         s_arready,
   output logic [DATA_W+ID_W+2:0]                   s_r_bus,
   output logic [NUM_M-1:0]                         s_rvalid,
   input  logic [NUM_M-1:0]                         s_rready,
   input  logic [NUM_M*(ADDR_W+ID_W+13)-1:0]        s_aw_bus,
   input  logic [NUM_M-1:0]                         s_awvalid,
   output logic [NUM_M-1:0]                         s_awready,
   input  logic [NUM_M*(DATA_W+DATA_W/8+1)-1:0]     s_w_bus,
   input  logic [NUM_M-1:0]                         s_wvalid,
   output logic [NUM_M-1:0]                         s_wready,
   output logic [ID_W+1:0]                          s_b_bus,
   output logic [NUM_M-1:0]                         s_bvalid,
   input  logic [NUM_M-1:0]                         s_bready,
   output logic [ADDR_W+ID_W+12:0]                  m_ar_bus,
   output logic                                     m_arvalid,
   input  logic                                     m_arready,
   input  logic [DATA_W+ID_W+2:0]                   m_r_bus,
   input  logic                                     m_rvalid,
   output logic                                     m_rready,
   output logic [ADDR_W+ID_W+12:0]                  m_aw_bus,
   output logic                                     m_awvalid,
   input  logic                                     m_awready,
   output logic [DATA_W+DATA_W/8:0]                 m_w_bus,
   output logic                                     m_wvalid,
   input  logic                                     m_wready,
   input  logic [ID_W+1:0]                          m_b_bus,
   input  logic                                     m_bvalid,
   output logic                                     m_bready
);

   localparam int AX_W  = ADDR_W + ID_W + 13;
   localparam int W_W   = DATA_W + DATA_W/8 + 1;
   localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_t;
   typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_t;

   rd_state_t         rd_state, rd_state_nxt;
   wr_state_t         wr_state, wr_state_nxt;
   logic [IDX_W-1:0]  rd_g, wr_g;
   logic [IDX_W-1:0]  rd_pick, wr_pick;
   logic [7:0]        rd_beats, wr_beats;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
      return (g == IDX_W'(NUM_M-1)) ? '0 : g + IDX_W'(1);
   endfunction

`ifdef AXI_ARB_RR_EN
   logic [IDX_W-1:0]  rd_ptr, wr_ptr;

   // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
   function automatic logic [IDX_W-1:0] arb(input logic [NUM_M-1:0] req, input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] hi, lo;
      logic             hit;
      hi  = '0;
      lo  = '0;
      hit = 1'b0;
      for (int i = NUM_M-1; i >= 0; i--) begin
         if (req[i]) begin
            lo = IDX_W'(i);
            if (IDX_W'(i) >= ptr) begin
               hi  = IDX_W'(i);
               hit = 1'b1;
            end
         end
      end
      return hit ? hi : lo;
   endfunction

   always_comb begin
      rd_pick = arb(s_arvalid, rd_ptr);
      wr_pick = arb(s_awvalid, wr_ptr);
   end
`else
   function automatic logic [IDX_W-1:0] arb(input logic [NUM_M-1:0] req);
      logic [IDX_W-1:0] pick;
      pick = '0;
      for (int i = NUM_M-1; i >= 0; i--)
         if (req[i]) pick = IDX_W'(i);
      return pick;
   endfunction

   always_comb begin
      rd_pick = arb(s_arvalid);
      wr_pick = arb(s_awvalid);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_state <= RD_IDLE;
         wr_state <= WR_IDLE;
         rd_g     <= '0;
         wr_g     <= '0;
         rd_beats <= '0;
         wr_beats <= '0;
`ifdef AXI_ARB_RR_EN
         rd_ptr   <= '0;
         wr_ptr   <= '0;
`endif
      end else begin
         rd_state <= rd_state_nxt;
         wr_state <= wr_state_nxt;
         if (rd_state == RD_IDLE && |s_arvalid) begin
            rd_g <= rd_pick;
`ifdef AXI_ARB_RR_EN
            rd_ptr <= next_idx(rd_pick);
`endif
         end
         if (wr_state == WR_IDLE && |s_awvalid) begin
            wr_g <= wr_pick;
`ifdef AXI_ARB_RR_EN
            wr_ptr <= next_idx(wr_pick);
`endif
         end
         // Beat counters are informational only; rlast/wlast alone end a burst.
         if (rd_state == RD_AR)
            rd_beats <= '0;
         else if (rd_state == RD_R && m_rvalid && m_rready)
            rd_beats <= rd_beats + 8'd1;
         if (wr_state == WR_AW)
            wr_beats <= '0;
         else if (wr_state == WR_W && m_wvalid && m_wready)
            wr_beats <= wr_beats + 8'd1;
      end
   end

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         RD_IDLE: if (|s_arvalid)                        rd_state_nxt = RD_AR;
         RD_AR:   if (m_arvalid && m_arready)            rd_state_nxt = RD_R;
         RD_R:    if (m_rvalid && m_rready && m_r_bus[0]) rd_state_nxt = RD_IDLE;
         default:                                        rd_state_nxt = RD_IDLE;
      endcase
   end

   always_comb begin
      wr_state_nxt = wr_state;
      case (wr_state)
         WR_IDLE: if (|s_awvalid)                        wr_state_nxt = WR_AW;
         WR_AW:   if (m_awvalid && m_awready)            wr_state_nxt = WR_W;
         WR_W:    if (m_wvalid && m_wready && m_w_bus[0]) wr_state_nxt = WR_B;
         WR_B:    if (m_bvalid && m_bready)              wr_state_nxt = WR_IDLE;
         default:                                        wr_state_nxt = WR_IDLE;
      endcase
   end

   // Payloads follow the registered grant unconditionally; only handshakes are gated by state.
   always_comb begin
      m_ar_bus  = s_ar_bus[rd_g*AX_W +: AX_W];
      m_aw_bus  = s_aw_bus[wr_g*AX_W +: AX_W];
      m_w_bus   = s_w_bus[wr_g*W_W +: W_W];
      s_r_bus   = m_r_bus;
      s_b_bus   = m_b_bus;
      m_arvalid = 1'b0;
      s_arready = '0;
      s_rvalid  = '0;
      m_rready  = 1'b0;
      m_awvalid = 1'b0;
      s_awready = '0;
      m_wvalid  = 1'b0;
      s_wready  = '0;
      s_bvalid  = '0;
      m_bready  = 1'b0;
      case (rd_state)
         RD_AR: begin
            m_arvalid       = s_arvalid[rd_g];
            s_arready[rd_g] = m_arready;
         end
         RD_R: begin
            s_rvalid[rd_g] = m_rvalid;
            m_rready       = s_rready[rd_g];
         end
         default: ;
      endcase
      case (wr_state)
         WR_AW: begin
            m_awvalid       = s_awvalid[wr_g];
            s_awready[wr_g] = m_awready;
         end
         WR_W: begin
            m_wvalid       = s_wvalid[wr_g];
            s_wready[wr_g] = m_wready;
         end
         WR_B: begin
            s_bvalid[wr_g] = m_bvalid;
            m_bready       = s_bready[wr_g];
         end
         default: ;
      endcase
   end

endmodule
